// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the DAC playback controller: FSM states, gpio bit
// positions, stream width and the phase-sequencing helpers.
package dac_ctrl_pkg;

    localparam int DATA_W = 128;
    localparam int LEN_W  = 32;
    localparam int GPIO_W = 16;

    localparam int DEF_TRIGGER_OVERRIDE_BIT = 0;
    localparam int DEF_READY_BIT            = 1;
    localparam int DEF_SDATA_BIT            = 4;
    localparam int DEF_BUFFER_FLUSH_BIT     = 5;
    localparam int DEF_POST_ZEROS_SCLK      = 7;
    localparam int DEF_CYCLES_SCLK          = 8;
    localparam int DEF_PRE_WAVEFORM_SCLK    = 10;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        PLAY,
        POST,
        CLEANUP
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0] pre;
        logic [LEN_W-1:0] wave;
        logic [LEN_W-1:0] post;
    } lengths_t;

    // First non-empty phase after cur in PRE->PLAY->POST order; CLEANUP when none remain.
    function automatic state_t next_phase(input state_t cur, input lengths_t len);
        state_t nxt;
        nxt = CLEANUP;
        if (cur == IDLE && len.pre != '0)
            nxt = PRE;
        else if ((cur == IDLE || cur == PRE) && len.wave != '0)
            nxt = PLAY;
        else if (cur != POST && len.post != '0)
            nxt = POST;
        return nxt;
    endfunction

    function automatic logic [LEN_W-1:0] phase_len(input state_t st, input lengths_t len);
        logic [LEN_W-1:0] l;
        case (st)
            PRE:     l = len.pre;
            PLAY:    l = len.wave;
            POST:    l = len.post;
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/shift_register.sv
// Serial-in, parallel-out length register: shifts sdata in MSB-first on each shift_en pulse.
module shift_register #(
    parameter int WIDTH = 32
) (
    input  logic             rf_clk,
    input  logic             rf_reset,
    input  logic             shift_en,
    input  logic             sdata,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rf_clk or negedge rf_reset) begin
        if (!rf_reset)
            q <= '0;
        else if (shift_en)
            q <= {q[WIDTH-2:0], sdata};
    end

endmodule

// File: rtl/dac_playback_controller.sv
// Trigger-driven waveform playback to a DAC AXIS input: pre zeros, waveform words, post zeros,
// with serially loaded lengths, continuous-replay override and a flush/drain escape.
module dac_playback_controller
    import dac_ctrl_pkg::*;
#(
    parameter int TRIGGER_OVERRIDE_BIT = DEF_TRIGGER_OVERRIDE_BIT,
    parameter int READY_BIT            = DEF_READY_BIT,
    parameter int SDATA_BIT            = DEF_SDATA_BIT,
    parameter int BUFFER_FLUSH_BIT     = DEF_BUFFER_FLUSH_BIT,
    parameter int POST_ZEROS_SCLK      = DEF_POST_ZEROS_SCLK,
    parameter int CYCLES_SCLK          = DEF_CYCLES_SCLK,
    parameter int PRE_WAVEFORM_SCLK    = DEF_PRE_WAVEFORM_SCLK
) (
    input  logic              rf_clk,
    input  logic              rf_reset,
    input  logic              ext_trigger,
    input  logic [GPIO_W-1:0] gpio_in,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              adc_trig_out,
    output logic              busy,
    output logic              underrun
);

    logic [GPIO_W-1:0] gpio_meta, gpio_sync;
    logic [2:0]        sclk_now, sclk_prev, sclk_rise;
    logic              unused_gpio;

    always_ff @(posedge rf_clk or negedge rf_reset) begin
        if (!rf_reset) begin
            gpio_meta <= '0;
            gpio_sync <= '0;
            sclk_prev <= '0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            sclk_prev <= sclk_now;
        end
    end

    assign sclk_now    = {gpio_sync[PRE_WAVEFORM_SCLK], gpio_sync[CYCLES_SCLK], gpio_sync[POST_ZEROS_SCLK]};
    assign sclk_rise   = sclk_now & ~sclk_prev;
    // Bits not decoded here belong to other blocks sharing the gpio bank.
    assign unused_gpio = ^gpio_sync;

    logic             trig, flush, override;
    logic [LEN_W-1:0] live_pre, live_wave, live_post;
    lengths_t         live;

    assign trig     = ext_trigger | gpio_sync[READY_BIT];
    assign flush    = gpio_sync[BUFFER_FLUSH_BIT];
    assign override = gpio_sync[TRIGGER_OVERRIDE_BIT];

    shift_register #(.WIDTH(LEN_W)) u_pre_len (
        .rf_clk   (rf_clk),
        .rf_reset (rf_reset),
        .shift_en (sclk_rise[2]),
        .sdata    (gpio_sync[SDATA_BIT]),
        .q        (live_pre)
    );

    shift_register #(.WIDTH(LEN_W)) u_wave_len (
        .rf_clk   (rf_clk),
        .rf_reset (rf_reset),
        .shift_en (sclk_rise[1]),
        .sdata    (gpio_sync[SDATA_BIT]),
        .q        (live_wave)
    );

    shift_register #(.WIDTH(LEN_W)) u_post_len (
        .rf_clk   (rf_clk),
        .rf_reset (rf_reset),
        .shift_en (sclk_rise[0]),
        .sdata    (gpio_sync[SDATA_BIT]),
        .q        (live_post)
    );

    assign live = '{pre: live_pre, wave: live_wave, post: live_post};

    state_t            state, state_next;
    logic [LEN_W-1:0]  count, count_next;
    lengths_t          lens, lens_next;
    logic [DATA_W-1:0] data_next;
    logic              trig_out_next, underrun_next;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_next    = state;
        count_next    = count;
        lens_next     = lens;
        data_next     = m_axis_tdata;
        trig_out_next = adc_trig_out;
        underrun_next = underrun;
        s_axis_tready = 1'b0;

        if (flush) begin
            state_next    = IDLE;
            count_next    = '0;
            data_next     = '0;
            trig_out_next = 1'b0;
            s_axis_tready = 1'b1;
        end else if (m_axis_tready) begin
            data_next     = '0;
            trig_out_next = 1'b0;
            count_next    = count + 32'd1;
            case (state)
                IDLE: begin
                    count_next = '0;
                    if (trig) begin
                        lens_next     = live;
                        underrun_next = 1'b0;
                        state_next    = next_phase(IDLE, live);
                    end
                end
                PRE, PLAY, POST: begin
                    if (state == PLAY) begin
                        s_axis_tready = 1'b1;
                        trig_out_next = 1'b1;
                        // Real-time playback: a missing source word becomes a zero, never a stall.
                        if (s_axis_tvalid)
                            data_next = s_axis_tdata;
                        else
                            underrun_next = 1'b1;
                    end
                    if (count == phase_len(state, lens) - 32'd1) begin
                        count_next = '0;
                        state_next = next_phase(state, lens);
                        if (state_next == CLEANUP && override) begin
                            lens_next  = live;
                            state_next = next_phase(IDLE, live);
                        end
                    end
                end
                CLEANUP: begin
                    count_next = '0;
                    if (!trig)
                        state_next = IDLE;
                end
                default: begin
                    count_next = '0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge rf_clk or negedge rf_reset) begin
        if (!rf_reset) begin
            state         <= IDLE;
            count         <= '0;
            lens          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            adc_trig_out  <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            lens          <= lens_next;
            m_axis_tdata  <= data_next;
            m_axis_tvalid <= 1'b1;
            adc_trig_out  <= trig_out_next;
            underrun      <= underrun_next;
        end
    end

    assign busy = (state == PRE) || (state == PLAY) || (state == POST);

endmodule

// File: tb/tb_dac_playback_controller.sv
// Scoreboard bench for dac_playback_controller: a queue model of the expected output stream,
// a source model feeding random waveform words, and a monitor checking every accepted beat.
`timescale 1ns/1ps
module tb_dac_playback_controller;
    import dac_ctrl_pkg::*;

    logic              rf_clk = 1'b0;
    logic              rf_reset;
    logic              ext_trigger;
    logic [GPIO_W-1:0] gpio_in;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              adc_trig_out;
    logic              busy;
    logic              underrun;

    always #5 rf_clk = ~rf_clk;

    dac_playback_controller dut (
        .rf_clk        (rf_clk),
        .rf_reset      (rf_reset),
        .ext_trigger   (ext_trigger),
        .gpio_in       (gpio_in),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .adc_trig_out  (adc_trig_out),
        .busy          (busy),
        .underrun      (underrun)
    );

    typedef struct packed {
        logic              care;
        logic [DATA_W-1:0] data;
        logic              trig;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] ref_q[$];
    int                gap_slot = -1;
    int                slot;
    int                checks   = 0;
    int                failures = 0;
    beat_t             mon_beat;

    task automatic check(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every beat the DAC accepts is popped against the expected stream.
    always @(negedge rf_clk) begin
        if (rf_reset && m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
            mon_beat = exp_q.pop_front();
            if (mon_beat.care)
                check("m_axis_beat", {m_axis_tdata, adc_trig_out}, {mon_beat.data, mon_beat.trig});
        end
    end

    // Source model: presents src_q head, drops valid on the configured PLAY slot.
    initial begin
        logic hs, was_busy;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        slot          = 0;
        forever begin
            @(negedge rf_clk);
            hs       = s_axis_tready;
            was_busy = busy;
            @(posedge rf_clk);
            #1;
            if (hs) begin
                if (s_axis_tvalid && src_q.size() > 0)
                    void'(src_q.pop_front());
                slot++;
            end else if (!was_busy) begin
                slot = 0;
            end
            s_axis_tvalid = (src_q.size() > 0) && (slot != gap_slot);
            s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge rf_clk);
            #1;
        end
    endtask

    task automatic load_len(input int sclk_bit, input logic [31:0] value);
        for (int i = 31; i >= 0; i--) begin
            gpio_in[DEF_SDATA_BIT] = value[i];
            cycles(3);
            gpio_in[sclk_bit] = 1'b1;
            cycles(3);
            gpio_in[sclk_bit] = 1'b0;
            cycles(3);
        end
    endtask

    task automatic configure(input int pre, input int wave, input int post);
        load_len(DEF_PRE_WAVEFORM_SCLK, pre);
        load_len(DEF_CYCLES_SCLK, wave);
        load_len(DEF_POST_ZEROS_SCLK, post);
    endtask

    task automatic load_source(input int n);
        logic [DATA_W-1:0] w;
        src_q.delete();
        ref_q.delete();
        repeat (n) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            if (w == '0)
                w = 1;
            src_q.push_back(w);
            ref_q.push_back(w);
        end
    endtask

    function automatic beat_t mk(input logic care, input logic [DATA_W-1:0] d, input logic t);
        beat_t b;
        b.care = care;
        b.data = d;
        b.trig = t;
        return b;
    endfunction

    // Expected stream of one pass: pre zeros, wave words (zero on a source gap), post zeros.
    task automatic push_run(input int pre, input int wave, input int post, input int gap, input int trail);
        for (int i = 0; i < pre; i++)
            exp_q.push_back(mk(1'b1, '0, 1'b0));
        for (int j = 0; j < wave; j++) begin
            if (j == gap || ref_q.size() == 0)
                exp_q.push_back(mk(1'b1, '0, 1'b1));
            else
                exp_q.push_back(mk(1'b1, ref_q.pop_front(), 1'b1));
        end
        for (int i = 0; i < post + trail; i++)
            exp_q.push_back(mk(1'b1, '0, 1'b0));
    endtask

    // Two accepted beats precede the sequence: the word on the bus and the IDLE trigger-cycle word.
    task automatic start_trigger();
        exp_q.push_front(mk(1'b0, '0, 1'b0));
        exp_q.push_front(mk(1'b0, '0, 1'b0));
        ext_trigger = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycles(1);
            n++;
        end
        check("scoreboard_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            cycles(1);
            n++;
        end
        check("return_idle", busy, 0);
    endtask

    task automatic pulse_run(input int pre, input int wave, input int post, input int gap, input int trail);
        push_run(pre, wave, post, gap, trail);
        start_trigger();
        cycles(1);
        ext_trigger = 1'b0;
        wait_drain(pre + wave + post + trail + 60);
        wait_idle(50);
    endtask

    initial begin
        int n, depth, pre, wave, post;
        rf_reset      = 1'b0;
        ext_trigger   = 1'b0;
        gpio_in       = '0;
        m_axis_tready = 1'b1;
        #23;
        check("reset_tvalid", m_axis_tvalid, 0);
        check("reset_tdata", m_axis_tdata, 0);
        check("reset_s_tready", s_axis_tready, 0);
        check("reset_trig_out", adc_trig_out, 0);
        check("reset_busy", busy, 0);
        check("reset_underrun", underrun, 0);
        @(posedge rf_clk);
        #1;
        rf_reset = 1'b1;
        cycles(2);
        check("tvalid_after_reset", m_axis_tvalid, 1);

        // Pulse trigger: 2 zeros, 4 words with adc_trig_out, 3 zeros, then idle zeros.
        load_source(10);
        configure(2, 4, 3);
        pulse_run(2, 4, 3, -1, 3);

        // Held trigger: a single playback, no restart while the trigger stays high.
        load_source(10);
        push_run(2, 4, 3, -1, 10);
        start_trigger();
        cycles(30);
        check("held_trigger_single", busy, 0);
        ext_trigger = 1'b0;
        wait_drain(20);
        wait_idle(20);

        // Continuous replay: W0 W1 W2 0 W3 W4 W5 0 ...
        load_source(40);
        configure(0, 3, 1);
        gpio_in[DEF_TRIGGER_OVERRIDE_BIT] = 1'b1;
        cycles(4);
        push_run(0, 3, 1, -1, 0);
        push_run(0, 3, 1, -1, 0);
        push_run(0, 3, 1, -1, 0);
        start_trigger();
        cycles(1);
        ext_trigger = 1'b0;
        wait_drain(80);
        gpio_in[DEF_TRIGGER_OVERRIDE_BIT] = 1'b0;
        wait_idle(100);

        // Source gap on the 2nd PLAY word: zero emitted, length unchanged, underrun sticky.
        load_source(10);
        configure(1, 4, 1);
        gap_slot = 1;
        cycles(2);
        pulse_run(1, 4, 1, 1, 2);
        check("underrun_set", underrun, 1);
        gap_slot = -1;

        for (int r = 0; r < 4; r++) begin
            pre  = $urandom_range(0, 5);
            wave = $urandom_range(0, 5);
            post = $urandom_range(0, 5);
            load_source(8);
            configure(pre, wave, post);
            pulse_run(pre, wave, post, -1, 2);
            check("underrun_clear", underrun, 0);
        end

        // Back-pressure mid-PLAY: outputs held, nothing consumed, stream resumes intact.
        load_source(12);
        configure(1, 8, 1);
        push_run(1, 8, 1, -1, 2);
        start_trigger();
        cycles(1);
        ext_trigger = 1'b0;
        n = 0;
        while (!adc_trig_out && n < 50) begin
            cycles(1);
            n++;
        end
        check("play_started", adc_trig_out, 1);
        cycles(2);
        m_axis_tready = 1'b0;
        cycles(1);
        depth = src_q.size();
        for (int i = 0; i < 4; i++) begin
            check("stall_s_tready", s_axis_tready, 0);
            cycles(1);
        end
        check("stall_no_consume", src_q.size(), depth);
        m_axis_tready = 1'b1;
        wait_drain(60);
        wait_idle(50);

        // Flush mid-PLAY: idle, zeros, drain the source, ignore triggers.
        load_source(20);
        configure(2, 20, 2);
        push_run(2, 3, 0, -1, 0);
        start_trigger();
        cycles(1);
        ext_trigger = 1'b0;
        wait_drain(40);
        gpio_in[DEF_BUFFER_FLUSH_BIT] = 1'b1;
        cycles(4);
        check("flush_busy", busy, 0);
        check("flush_tdata", m_axis_tdata, 0);
        check("flush_trig_out", adc_trig_out, 0);
        check("flush_s_tready", s_axis_tready, 1);
        check("flush_tvalid", m_axis_tvalid, 1);
        ext_trigger = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("flush_ignores_trig", busy, 0);
        end
        ext_trigger = 1'b0;
        cycles(20);
        check("flush_drained", src_q.size(), 0);
        gpio_in[DEF_BUFFER_FLUSH_BIT] = 1'b0;
        cycles(4);
        wait_idle(20);

        // Reset mid-POST: everything back to reset values, lengths cleared.
        load_source(6);
        configure(1, 2, 30);
        gap_slot = 0;
        cycles(2);
        push_run(1, 2, 4, 0, 0);
        start_trigger();
        cycles(1);
        ext_trigger = 1'b0;
        wait_drain(40);
        check("post_busy", busy, 1);
        check("post_underrun", underrun, 1);
        #2;
        rf_reset = 1'b0;
        #1;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_tdata", m_axis_tdata, 0);
        check("midrst_trig_out", adc_trig_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_s_tready", s_axis_tready, 0);
        gap_slot = -1;
        cycles(3);
        rf_reset = 1'b1;
        cycles(3);
        check("tvalid_after_midrst", m_axis_tvalid, 1);

        // Lengths were cleared: a trigger goes straight to CLEANUP and emits only zeros.
        push_run(0, 0, 0, -1, 4);
        start_trigger();
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            if (i == 0)
                ext_trigger = 1'b0;
            check("zero_len_not_busy", busy, 0);
        end
        wait_drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
